// File: rtl/jpeg_entropy_bit_reader.sv
// JPEG entropy-segment bit reader: strips 0xFF00 stuffing, traps markers and
// exposes an MSB-first peek/consume window. Optional macro: JPEG_RST_ALIGN_EN.
module jpeg_entropy_bit_reader #(
  parameter int BUF_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [PEEK_W-1:0] peek_data,
  output logic [5:0]        peek_avail,
  input  logic              consume_valid,
  input  logic [4:0]        consume_len,
  output logic              marker_valid,
  output logic [7:0]        marker_code,
  input  logic              marker_ack,
  output logic              error
);

  typedef enum logic [1:0] {NORMAL, GOT_FF, MARKER} state_t;

  state_t           state_reg, state_next;
  logic [BUF_W-1:0] buffer_reg, buffer_next;
  logic [5:0]       count_reg, count_next;
  logic             marker_valid_reg, marker_valid_next;
  logic [7:0]       marker_code_reg, marker_code_next;
  logic             error_reg, error_next;
`ifdef JPEG_RST_ALIGN_EN
  logic [2:0]       rst_idx_reg, rst_idx_next;
`endif

  logic             accept, consume_ok, ack, flush, append;
  logic [BUF_W-1:0] buf_mid, append_ext;
  logic [5:0]       cnt_mid, tail_sh;
  logic [7:0]       append_byte;

  assign in_ready     = (state_reg != MARKER) && (count_reg <= 6'(BUF_W-8));
  assign peek_data    = buffer_reg[BUF_W-1 -: PEEK_W];
  assign peek_avail   = count_reg;
  assign marker_valid = marker_valid_reg;
  assign marker_code  = marker_code_reg;
  assign error        = error_reg;

  always_comb begin
    state_next        = state_reg;
    marker_valid_next = marker_valid_reg;
    marker_code_next  = marker_code_reg;
    error_next        = error_reg;
`ifdef JPEG_RST_ALIGN_EN
    rst_idx_next      = rst_idx_reg;
`endif
    accept      = in_valid && in_ready;
    consume_ok  = consume_valid && (consume_len != 5'd0) &&
                  (int'(consume_len) <= PEEK_W) &&
                  ({1'b0, consume_len} <= count_reg);
    ack         = (state_reg == MARKER) && marker_ack && marker_valid_reg;
    flush       = 1'b0;
`ifdef JPEG_RST_ALIGN_EN
    flush       = ack && (marker_code_reg[7:3] == 5'b11010);
`endif
    append      = 1'b0;
    append_byte = in_data;

    // Consume is applied first so the appended byte lands at the new tail.
    buf_mid = buffer_reg;
    cnt_mid = count_reg;
    if (!flush) begin
      if (consume_ok) begin
        buf_mid = buffer_reg << consume_len;
        cnt_mid = count_reg - {1'b0, consume_len};
      end else if (consume_valid) begin
        error_next = 1'b1;
      end
    end

    case (state_reg)
      NORMAL: begin
        if (accept) begin
          if (in_data == 8'hFF) state_next = GOT_FF;
          else                  append = 1'b1;
        end
      end
      GOT_FF: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            append      = 1'b1;
            append_byte = 8'hFF;
            state_next  = NORMAL;
          end else if (in_data != 8'hFF) begin
            marker_code_next  = in_data;
            marker_valid_next = 1'b1;
            state_next        = MARKER;
          end
        end
      end
      MARKER: begin
        if (ack) begin
          marker_valid_next = 1'b0;
          state_next        = NORMAL;
        end
      end
      default: state_next = NORMAL;
    endcase

    tail_sh    = 6'(BUF_W-8) - cnt_mid;
    append_ext = {{(BUF_W-8){1'b0}}, append_byte} << tail_sh;
    if (append) begin
      buffer_next = buf_mid | append_ext;
      count_next  = cnt_mid + 6'd8;
    end else begin
      buffer_next = buf_mid;
      count_next  = cnt_mid;
    end

`ifdef JPEG_RST_ALIGN_EN
    if (flush) begin
      buffer_next  = '0;
      count_next   = 6'd0;
      if (rst_idx_reg != marker_code_reg[2:0]) error_next = 1'b1;
      rst_idx_next = rst_idx_reg + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= NORMAL;
      buffer_reg       <= '0;
      count_reg        <= 6'd0;
      marker_valid_reg <= 1'b0;
      marker_code_reg  <= 8'h00;
      error_reg        <= 1'b0;
`ifdef JPEG_RST_ALIGN_EN
      rst_idx_reg      <= 3'd0;
`endif
    end else begin
      state_reg        <= state_next;
      buffer_reg       <= buffer_next;
      count_reg        <= count_next;
      marker_valid_reg <= marker_valid_next;
      marker_code_reg  <= marker_code_next;
      error_reg        <= error_next;
`ifdef JPEG_RST_ALIGN_EN
      rst_idx_reg      <= rst_idx_next;
`endif
    end
  end

endmodule

// File: tb/tb_jpeg_entropy_bit_reader.sv
// Directed self-checking bench for jpeg_entropy_bit_reader.
module tb_jpeg_entropy_bit_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] peek_data;
  logic [5:0]  peek_avail;
  logic        consume_valid;
  logic [4:0]  consume_len;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        error;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  jpeg_entropy_bit_reader #(.BUF_W(32), .PEEK_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .peek_data(peek_data), .peek_avail(peek_avail),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_ack(marker_ack), .error(error)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    consume_valid = 1'b0; consume_len = 5'd0; marker_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_consume(input logic [4:0] n);
    consume_valid = 1'b1; consume_len = n;
    @(negedge clk);
    consume_valid = 1'b0;
  endtask

  task automatic send_ack();
    marker_ack = 1'b1;
    @(negedge clk);
    marker_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (peek_avail !== 6'd0) begin tests_failed++; $display("FAIL reset_avail got %0d expected 0", peek_avail); end
    tests_run++; if (peek_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_peek got %h expected 0000", peek_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b expected 1", in_ready); end
    tests_run++; if (marker_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mvalid got %b expected 0", marker_valid); end
    tests_run++; if (marker_code !== 8'h00) begin tests_failed++; $display("FAIL reset_mcode got %h expected 00", marker_code); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b expected 0", error); end
    $display("[TB] reset: avail=%0d peek=%h ready=%b", peek_avail, peek_data, in_ready);
  endtask

  task automatic test_plain();
    do_reset();
    send_byte(8'h12);
    tests_run++; if (peek_avail !== 6'd8) begin tests_failed++; $display("FAIL plain_latency got %0d expected 8", peek_avail); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL plain_ready1 got %b expected 1", in_ready); end
    send_byte(8'h34);
    tests_run++; if (peek_avail !== 6'd16) begin tests_failed++; $display("FAIL plain_avail got %0d expected 16", peek_avail); end
    tests_run++; if (peek_data !== 16'h1234) begin tests_failed++; $display("FAIL plain_peek got %h expected 1234", peek_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL plain_ready2 got %b expected 1", in_ready); end
    $display("[TB] plain 12,34: avail=%0d peek=%h", peek_avail, peek_data);
  endtask

  task automatic test_stuffing();
    do_reset();
    send_byte(8'hFF);
    tests_run++; if (peek_avail !== 6'd0) begin tests_failed++; $display("FAIL stuff_ff_pending got %0d expected 0", peek_avail); end
    send_byte(8'h00);
    send_byte(8'hA5);
    tests_run++; if (peek_avail !== 6'd16) begin tests_failed++; $display("FAIL stuff_avail got %0d expected 16", peek_avail); end
    tests_run++; if (peek_data !== 16'hFFA5) begin tests_failed++; $display("FAIL stuff_peek got %h expected ffa5", peek_data); end
    tests_run++; if (marker_valid !== 1'b0) begin tests_failed++; $display("FAIL stuff_no_marker got %b expected 0", marker_valid); end
    $display("[TB] stuffing ff,00,a5: avail=%0d peek=%h", peek_avail, peek_data);
  endtask

  task automatic test_full();
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready24 got %b expected 1", in_ready); end
    send_byte(8'h04);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got %b expected 0", in_ready); end
    tests_run++; if (peek_avail !== 6'd32) begin tests_failed++; $display("FAIL full_avail got %0d expected 32", peek_avail); end
    tests_run++; if (peek_data !== 16'h0102) begin tests_failed++; $display("FAIL full_peek got %h expected 0102", peek_data); end
    send_byte(8'h99);
    tests_run++; if (peek_avail !== 6'd32) begin tests_failed++; $display("FAIL full_blocked got %0d expected 32", peek_avail); end
    send_consume(5'd8);
    tests_run++; if (peek_data !== 16'h0203) begin tests_failed++; $display("FAIL drain_peek got %h expected 0203", peek_data); end
    tests_run++; if (peek_avail !== 6'd24) begin tests_failed++; $display("FAIL drain_avail got %0d expected 24", peek_avail); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_ready got %b expected 1", in_ready); end
    send_consume(5'd16);
    tests_run++; if (peek_data !== 16'h0400) begin tests_failed++; $display("FAIL drain16_peek got %h expected 0400", peek_data); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL drain16_error got %b expected 0", error); end
    $display("[TB] full/drain: avail=%0d peek=%h ready=%b", peek_avail, peek_data, in_ready);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'hC0);
    in_valid = 1'b1; in_data = 8'h55;
    consume_valid = 1'b1; consume_len = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; consume_valid = 1'b0;
    tests_run++; if (peek_avail !== 6'd12) begin tests_failed++; $display("FAIL b2b_avail got %0d expected 12", peek_avail); end
    tests_run++; if (peek_data !== 16'h0550) begin tests_failed++; $display("FAIL b2b_peek got %h expected 0550", peek_data); end
    $display("[TB] append+consume: avail=%0d peek=%h", peek_avail, peek_data);
  endtask

  task automatic test_consume_errors();
    do_reset();
    send_consume(5'd0);
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL err_len0 got %b expected 1", error); end
    do_reset();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_consume(5'd17);
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL err_gt_peek got %b expected 1", error); end
    tests_run++; if (peek_avail !== 6'd24) begin tests_failed++; $display("FAIL err_ignored got %0d expected 24", peek_avail); end
    send_consume(5'd1);
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b expected 1", error); end
    tests_run++; if (peek_data !== 16'h5577) begin tests_failed++; $display("FAIL err_then_ok got %h expected 5577", peek_data); end
    $display("[TB] consume errors: error=%b avail=%0d", error, peek_avail);
  endtask

  task automatic test_marker();
    do_reset();
    send_byte(8'hAB);
    send_byte(8'hFF); send_byte(8'hFF);
    tests_run++; if (marker_valid !== 1'b0) begin tests_failed++; $display("FAIL mk_fill_early got %b expected 0", marker_valid); end
    send_byte(8'hD9);
    tests_run++; if (marker_valid !== 1'b1) begin tests_failed++; $display("FAIL mk_valid got %b expected 1", marker_valid); end
    tests_run++; if (marker_code !== 8'hD9) begin tests_failed++; $display("FAIL mk_code got %h expected d9", marker_code); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mk_ready got %b expected 0", in_ready); end
    tests_run++; if (peek_avail !== 6'd8) begin tests_failed++; $display("FAIL mk_count got %0d expected 8", peek_avail); end
    send_byte(8'h11);
    tests_run++; if (peek_avail !== 6'd8) begin tests_failed++; $display("FAIL mk_blocked got %0d expected 8", peek_avail); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL mk_err_pre got %b expected 0", error); end
    send_consume(5'd20);
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL mk_err20 got %b expected 1", error); end
    send_consume(5'd4);
    tests_run++; if (peek_data !== 16'hB000) begin tests_failed++; $display("FAIL mk_drain got %h expected b000", peek_data); end
    send_ack();
    tests_run++; if (marker_valid !== 1'b0) begin tests_failed++; $display("FAIL mk_ack got %b expected 0", marker_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL mk_ready_after got %b expected 1", in_ready); end
    send_ack();
    send_byte(8'h3C);
    tests_run++; if (peek_data !== 16'hB3C0) begin tests_failed++; $display("FAIL mk_resume got %h expected b3c0", peek_data); end
    tests_run++; if (peek_avail !== 6'd12) begin tests_failed++; $display("FAIL mk_resume_avail got %0d expected 12", peek_avail); end
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL mk_err_sticky got %b expected 1", error); end
    $display("[TB] marker d9: code=%h error=%b avail=%0d", marker_code, error, peek_avail);
  endtask

  task automatic test_rst_marker();
    do_reset();
    send_byte(8'hF8);
    send_consume(5'd3);
    tests_run++; if (peek_avail !== 6'd5) begin tests_failed++; $display("FAIL rst_pre got %0d expected 5", peek_avail); end
    send_byte(8'hFF); send_byte(8'hD0);
    tests_run++; if (marker_code !== 8'hD0) begin tests_failed++; $display("FAIL rst_code got %h expected d0", marker_code); end
    send_ack();
`ifdef JPEG_RST_ALIGN_EN
    tests_run++; if (peek_avail !== 6'd0) begin tests_failed++; $display("FAIL rst_flush got %0d expected 0", peek_avail); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL rst_idx_ok got %b expected 0", error); end
    send_byte(8'hFF); send_byte(8'hD2);
    send_ack();
    tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL rst_idx_bad got %b expected 1", error); end
`else
    tests_run++; if (peek_avail !== 6'd5) begin tests_failed++; $display("FAIL rst_keep got %0d expected 5", peek_avail); end
    tests_run++; if (peek_data !== 16'hC000) begin tests_failed++; $display("FAIL rst_keep_peek got %h expected c000", peek_data); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL rst_no_err got %b expected 0", error); end
`endif
    $display("[TB] rst marker: avail=%0d error=%b", peek_avail, error);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    consume_valid = 1'b0; consume_len = 5'd0; marker_ack = 1'b0;
    test_reset();
    test_plain();
    test_stuffing();
    test_full();
    test_back_to_back();
    test_consume_errors();
    test_marker();
    test_rst_marker();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
